// File: rtl/rddma_pkg.sv
// Shared types and defaults for the read-DMA burst controller.
package rddma_pkg;

  localparam int unsigned LEN_W_DEF   = 16;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned TMO_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rddma_st_t;

  // Error cause encoding, reserved for a future status register.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ZERO_LEN = 2'd1,
    ERR_ABORT    = 2'd2,
    ERR_TMO      = 2'd3
  } rddma_err_t;

endpackage

// File: rtl/rddma_stall_wdt.sv
// Stall watchdog: counts consecutive enabled cycles without a kick and
// flags expiry on the TMO_CYC-th such cycle. rst is active-low, asynchronous.
module rddma_stall_wdt #(
  parameter int unsigned TMO_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic kick,
  output logic expired
);

  localparam int unsigned W = $clog2(TMO_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: cleared whenever disabled or kicked, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || kick) begin
      cnt_d = '0;
    end else if (cnt_q != W'(TMO_CYC - 1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle is the TMO_CYC-th consecutive stall cycle.
  assign expired = en && !kick && (cnt_q == W'(TMO_CYC - 1));

endmodule

// File: rtl/rddma_burst_ctrl.sv
// Read-DMA burst controller: pops a software-sized burst from the DMA FIFO,
// counting beats per burst and over lifetime, with done/busy/err status.
// Optional stall watchdog is enabled by defining RDDMA_TMO_EN.
module rddma_burst_ctrl
  import rddma_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             abort,
  input  logic             fifo_valid,
  output logic             fifo_ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] beat_cnt,
  output logic [CNT_W-1:0] cnt_total
);

  // A watchdog limit of zero cycles has no meaning.
  if (TMO_CYC < 1) begin : g_bad_tmo
    $error("rddma_burst_ctrl: TMO_CYC must be at least 1");
  end

  rddma_st_t        state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] cnt_total_q, cnt_total_d;
  logic             err_q, err_d;

  logic beat;
  logic last_beat;
  logic cmd_ok;
  logic cmd_bad;
  logic tmo_expired;

  // fifo_ready depends only on state, so a beat never waits on valid->ready.
  assign beat      = fifo_valid && (state_q == RUN);
  assign last_beat = beat && (beat_cnt_q == len_q - LEN_W'(1));
  assign cmd_ok    = (state_q == IDLE) && cmd_valid && (cmd_len != '0);
  assign cmd_bad   = (state_q == IDLE) && cmd_valid && (cmd_len == '0);

`ifdef RDDMA_TMO_EN
  rddma_stall_wdt #(
    .TMO_CYC (TMO_CYC)
  ) u_wdt (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .en      (state_q == RUN),
    .kick    (beat),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_ok) state_d = RUN;
      RUN:  if (abort || last_beat || tmo_expired) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state; counters shown straight from registers.
  always_comb begin
    cmd_ready  = (state_q == IDLE);
    fifo_ready = (state_q == RUN);
    busy       = (state_q == RUN);
    done       = (state_q == DONE);
    err        = err_q;
    beat_cnt   = beat_cnt_q;
    cnt_total  = cnt_total_q;
  end

  // Counter, length and error next values.
  always_comb begin
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    cnt_total_d = cnt_total_q;
    err_d       = err_q;
    if (cmd_ok) begin
      len_d      = cmd_len;
      beat_cnt_d = '0;
      err_d      = 1'b0;
    end
    if (cmd_bad) begin
      err_d = 1'b1;
    end
    if (beat) begin
      beat_cnt_d  = beat_cnt_q + LEN_W'(1);
      cnt_total_d = cnt_total_q + CNT_W'(1);
    end
    if ((state_q == RUN) && (abort || tmo_expired)) begin
      err_d = 1'b1;
    end
  end

  // Counter, length and error registers; reset discards any partial burst.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      len_q       <= '0;
      beat_cnt_q  <= '0;
      cnt_total_q <= '0;
      err_q       <= 1'b0;
    end else begin
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      cnt_total_q <= cnt_total_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_rddma_burst_ctrl.sv
// Directed bench for rddma_burst_ctrl. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_rddma_burst_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        cmd_valid;
  logic [15:0] cmd_len;
  logic        cmd_ready;
  logic        abort;
  logic        fifo_valid;
  logic        fifo_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] beat_cnt;
  logic [31:0] cnt_total;

  int checks = 0;
  int errors = 0;

  int n_beats, n_done, done_cyc, last_beat_cyc, busy_cyc, ready_gap;
  logic [31:0] tot_exp;

  always #5 sys_clk = ~sys_clk;

  rddma_burst_ctrl #(
    .LEN_W   (16),
    .CNT_W   (32),
    .TMO_CYC (16)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .abort      (abort),
    .fifo_valid (fifo_valid),
    .fifo_ready (fifo_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .beat_cnt   (beat_cnt),
    .cnt_total  (cnt_total)
  );

  // Issue a command at the current falling edge and run up to maxc cycles.
  // mode 0: valid always 1; mode 1: valid toggles 1,0,1,0; mode 2: valid 1 for first k beats.
  // abort_at >= 0: pulse abort once n_beats reaches that count while busy.
  task automatic run_burst(input logic [15:0] len, input int mode, input int k,
                           input int abort_at, input int maxc);
    n_beats = 0; n_done = 0; done_cyc = -1; last_beat_cyc = -1;
    busy_cyc = 0; ready_gap = 0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    fifo_valid = 1'b1;
    for (int c = 0; c < maxc; c++) begin
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      if (done) begin n_done++; done_cyc = c; end
      if (busy) begin busy_cyc++; if (!fifo_ready) ready_gap++; end
      case (mode)
        0:       fifo_valid = 1'b1;
        1:       fifo_valid = (c % 2 == 0);
        default: fifo_valid = (n_beats < k);
      endcase
      abort = (abort_at >= 0) && (n_beats == abort_at) && busy;
      if (fifo_valid && fifo_ready) begin n_beats++; last_beat_cyc = c; end
      if (n_done > 0 && c >= done_cyc + 2) break;
    end
    abort = 1'b0;
    fifo_valid = 1'b0;
    tot_exp = tot_exp + 32'(n_beats);
  endtask

  task automatic test_reset();
    sys_rst = 1'b0; cmd_valid = 1'b0; cmd_len = '0; abort = 1'b0; fifo_valid = 1'b1;
    tot_exp = '0;
    repeat (3) @(negedge sys_clk);
    checks++;
    if ({cmd_ready, fifo_ready, busy, done, err} !== 5'b10000 || beat_cnt !== 16'd0 || cnt_total !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b frdy=%b busy=%b done=%b err=%b bc=%0d tot=%0d want 1 0 0 0 0 0 0",
               cmd_ready, fifo_ready, busy, done, err, beat_cnt, cnt_total);
    end
    sys_rst = 1'b1;
    @(negedge sys_clk);
    checks++;
    if (cmd_ready !== 1'b1 || fifo_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b frdy=%b want 1 0", cmd_ready, fifo_ready);
    end
  endtask

  task automatic test_basic();
    run_burst(16'd4, 0, 0, -1, 40);
    checks++;
    if (n_beats !== 4) begin errors++; $display("FAIL t1_beats: got %0d want 4", n_beats); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL t1_done_pulses: got %0d want 1", n_done); end
    checks++;
    if (done_cyc - last_beat_cyc !== 1) begin
      errors++; $display("FAIL t1_done_latency: got %0d want 1", done_cyc - last_beat_cyc);
    end
    checks++;
    if (beat_cnt !== 16'd4 || cnt_total !== 32'd4) begin
      errors++; $display("FAIL t1_counts: got bc=%0d tot=%0d want 4 4", beat_cnt, cnt_total);
    end
    checks++;
    if (err !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL t1_idle_status: got err=%b rdy=%b want 0 1", err, cmd_ready);
    end
  endtask

  task automatic test_toggle();
    run_burst(16'd8, 1, 0, -1, 60);
    checks++;
    if (n_beats !== 8) begin errors++; $display("FAIL t2_beats: got %0d want 8", n_beats); end
    checks++;
    if (ready_gap !== 0 || busy_cyc !== 15) begin
      errors++; $display("FAIL t2_ready_in_run: got gaps=%0d run_cycles=%0d want 0 15", ready_gap, busy_cyc);
    end
    checks++;
    if (n_done !== 1 || done_cyc - last_beat_cyc !== 1) begin
      errors++; $display("FAIL t2_done: got pulses=%0d latency=%0d want 1 1", n_done, done_cyc - last_beat_cyc);
    end
    checks++;
    if (beat_cnt !== 16'd8 || cnt_total !== tot_exp) begin
      errors++; $display("FAIL t2_counts: got bc=%0d tot=%0d want 8 %0d", beat_cnt, cnt_total, tot_exp);
    end
  endtask

  task automatic test_zero_len();
    run_burst(16'd0, 0, 0, -1, 6);
    checks++;
    if (err !== 1'b1 || busy_cyc !== 0 || n_done !== 0 || n_beats !== 0) begin
      errors++; $display("FAIL t3_zero_len: got err=%b busy_cycles=%0d done=%0d beats=%0d want 1 0 0 0",
                         err, busy_cyc, n_done, n_beats);
    end
    checks++;
    if (cmd_ready !== 1'b1 || beat_cnt !== 16'd8) begin
      errors++; $display("FAIL t3_idle_kept: got rdy=%b bc=%0d want 1 8", cmd_ready, beat_cnt);
    end
    run_burst(16'd2, 0, 0, -1, 20);
    checks++;
    if (err !== 1'b0 || n_beats !== 2 || n_done !== 1 || beat_cnt !== 16'd2) begin
      errors++; $display("FAIL t3_recover: got err=%b beats=%0d done=%0d bc=%0d want 0 2 1 2",
                         err, n_beats, n_done, beat_cnt);
    end
  endtask

  task automatic test_abort();
    run_burst(16'd100, 0, 0, 10, 60);
    checks++;
    if (n_beats !== 11 || beat_cnt !== 16'd11) begin
      errors++; $display("FAIL t4_abort_count: got beats=%0d bc=%0d want 11 11", n_beats, beat_cnt);
    end
    checks++;
    if (err !== 1'b1 || n_done !== 1) begin
      errors++; $display("FAIL t4_abort_status: got err=%b done=%0d want 1 1", err, n_done);
    end
    checks++;
    if (cnt_total !== tot_exp) begin
      errors++; $display("FAIL t4_total: got %0d want %0d", cnt_total, tot_exp);
    end
  endtask

  task automatic test_wrap();
    force dut.cnt_total_q = 32'hFFFF_FFFE;
    @(negedge sys_clk);
    release dut.cnt_total_q;
    @(negedge sys_clk);
    tot_exp = 32'hFFFF_FFFE;
    checks++;
    if (cnt_total !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL t5_preload: got %h want fffffffe", cnt_total);
    end
    run_burst(16'd3, 0, 0, -1, 20);
    checks++;
    if (cnt_total !== 32'd1 || n_beats !== 3) begin
      errors++; $display("FAIL t5_wrap: got tot=%0d beats=%0d want 1 3", cnt_total, n_beats);
    end
  endtask

  task automatic test_stall();
`ifdef RDDMA_TMO_EN
    run_burst(16'd5, 2, 2, -1, 60);
    checks++;
    if (n_beats !== 2 || done_cyc !== 18 || n_done !== 1) begin
      errors++; $display("FAIL t6_tmo: got beats=%0d done_cycle=%0d pulses=%0d want 2 18 1",
                         n_beats, done_cyc, n_done);
    end
    checks++;
    if (err !== 1'b1 || beat_cnt !== 16'd2) begin
      errors++; $display("FAIL t6_tmo_status: got err=%b bc=%0d want 1 2", err, beat_cnt);
    end
`else
    run_burst(16'd5, 2, 2, -1, 1000);
    checks++;
    if (busy !== 1'b1 || n_done !== 0 || n_beats !== 2) begin
      errors++; $display("FAIL t6_no_tmo: got busy=%b done=%0d beats=%0d want 1 0 2", busy, n_done, n_beats);
    end
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    checks++;
    if (done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL t6_abort_end: got done=%b err=%b want 1 1", done, err);
    end
    @(negedge sys_clk);
`endif
    checks++;
    if (cnt_total !== tot_exp || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL t6_total: got tot=%0d rdy=%b want %0d 1", cnt_total, cmd_ready, tot_exp);
    end
  endtask

  task automatic test_reset_mid_burst();
    int c;
    cmd_valid = 1'b1; cmd_len = 16'd10; fifo_valid = 1'b1;
    c = 0;
    @(negedge sys_clk);
    cmd_valid = 1'b0;
    while (beat_cnt != 16'd3 && c < 20) begin
      @(negedge sys_clk);
      c++;
    end
    checks++;
    if (beat_cnt !== 16'd3 || busy !== 1'b1) begin
      errors++; $display("FAIL t7_reach_beat3: got bc=%0d busy=%b want 3 1", beat_cnt, busy);
    end
    sys_rst = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, fifo_ready, busy, done, err} !== 5'b10000 || beat_cnt !== 16'd0 || cnt_total !== 32'd0) begin
      errors++;
      $display("FAIL t7_async_reset: got rdy=%b frdy=%b busy=%b done=%b err=%b bc=%0d tot=%0d want 1 0 0 0 0 0 0",
               cmd_ready, fifo_ready, busy, done, err, beat_cnt, cnt_total);
    end
    @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (cmd_ready !== 1'b1 || fifo_ready !== 1'b0 || cnt_total !== 32'd0) begin
      errors++; $display("FAIL t7_idle_after: got rdy=%b frdy=%b tot=%0d want 1 0 0", cmd_ready, fifo_ready, cnt_total);
    end
    fifo_valid = 1'b0;
    tot_exp = '0;
  endtask

  task automatic test_back_to_back();
    run_burst(16'd1, 0, 0, -1, 10);
    checks++;
    if (n_beats !== 1 || n_done !== 1 || done_cyc !== 1) begin
      errors++; $display("FAIL t8_len1: got beats=%0d pulses=%0d done_cycle=%0d want 1 1 1", n_beats, n_done, done_cyc);
    end
    run_burst(16'd3, 0, 0, -1, 20);
    checks++;
    if (n_beats !== 3 || cnt_total !== tot_exp || beat_cnt !== 16'd3) begin
      errors++; $display("FAIL t8_second: got beats=%0d tot=%0d bc=%0d want 3 %0d 3", n_beats, cnt_total, beat_cnt, tot_exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_zero_len();
    test_abort();
    test_wrap();
    test_stall();
    test_reset_mid_burst();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
